// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light monitor:
// phases, error codes and lamp patterns.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_SYNC  = 3'b000,
    S_RED   = 3'b001,
    S_RA    = 3'b011,
    S_GREEN = 3'b100,
    S_AMBER = 3'b010,
    S_FAULT = 3'b111
  } state_t;

  localparam logic [2:0] RED       = 3'b001;
  localparam logic [2:0] RED_AMBER = 3'b011;
  localparam logic [2:0] GREEN     = 3'b100;
  localparam logic [2:0] AMBER     = 3'b010;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_PAT   = 2'b01;
  localparam logic [1:0] ERR_TRANS = 2'b10;
  localparam logic [1:0] ERR_DWELL = 2'b11;

  function automatic logic is_legal(
    input logic [2:0] p
  );
    return (p == RED) || (p == RED_AMBER) ||
           (p == GREEN) || (p == AMBER);
  endfunction

  function automatic logic [2:0] next_pat(
    input logic [2:0] p
  );
    logic [2:0] n;
    n = RED;
    unique case (p)
      RED:       n = RED_AMBER;
      RED_AMBER: n = GREEN;
      GREEN:     n = AMBER;
      default:   n = RED;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/traffic_monitor_if.sv
// Lamp observation inputs and monitor status
// outputs of the traffic light monitor.
interface traffic_monitor_if;
  logic       red;
  logic       amber;
  logic       green;
  logic       err_clr;
  logic [2:0] phase;
  logic       locked;
  logic       error;
  logic [1:0] err_code;
  logic [7:0] cycle_count;

  modport master (
    output red, amber, green, err_clr,
    input  phase, locked, error,
    input  err_code, cycle_count
  );

  modport slave (
    input  red, amber, green, err_clr,
    output phase, locked, error,
    output err_code, cycle_count
  );
endinterface

// File: rtl/sat_counter.sv
// 8-bit up counter with synchronous clear,
// sticking at 255.
module sat_counter (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= 8'd0;
    else if (inc && count != 8'hff)
      count <= count + 8'd1;
  end

endmodule

// File: rtl/traffic_monitor.sv
// Tracks the red/red-amber/green/amber lamp
// sequence and flags illegal or stuck patterns.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MAX_DWELL = 16
) (
  input logic              clk,
  input logic              rst_n,
  traffic_monitor_if.slave bus
);

  state_t     state, nxt_state;
  logic [1:0] code, nxt_code;
  logic [7:0] dwell, nxt_dwell;
  logic [7:0] cyc;
  logic       cyc_inc;
  logic [2:0] pat;

  assign pat = {bus.green, bus.amber, bus.red};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_SYNC;
      code  <= ERR_NONE;
      dwell <= 8'd0;
    end else begin
      state <= nxt_state;
      code  <= nxt_code;
      dwell <= nxt_dwell;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_code  = code;
    nxt_dwell = dwell;
    cyc_inc   = 1'b0;
    case (state)
      S_SYNC: begin
        nxt_dwell = 8'd0;
        if (!is_legal(pat)) begin
          nxt_state = S_FAULT;
          nxt_code  = ERR_PAT;
        end else if (pat == RED) begin
          nxt_state = S_RED;
          nxt_dwell = 8'd1;
        end
      end
      S_FAULT: begin
        nxt_dwell = 8'd0;
        if (bus.err_clr) begin
          nxt_state = S_SYNC;
          nxt_code  = ERR_NONE;
        end
      end
      default: begin
        unique case (1'b1)
          !is_legal(pat): begin
            nxt_state = S_FAULT;
            nxt_code  = ERR_PAT;
            nxt_dwell = 8'd0;
          end
          pat == state: begin
            if (dwell == 8'(MAX_DWELL)) begin
              nxt_state = S_FAULT;
              nxt_code  = ERR_DWELL;
              nxt_dwell = 8'd0;
            end else begin
              nxt_dwell = dwell + 8'd1;
            end
          end
          pat == next_pat(state): begin
            nxt_state = state_t'(pat);
            nxt_dwell = 8'd1;
            cyc_inc   = (state == S_AMBER);
          end
          default: begin
            nxt_state = S_FAULT;
            nxt_code  = ERR_TRANS;
            nxt_dwell = 8'd0;
          end
        endcase
      end
    endcase
  end

  // Reset folds into the counter's clear so a
  // reset edge never also counts a sequence.
  sat_counter u_cyc (
    .clk   (clk),
    .clr   (!rst_n),
    .inc   (cyc_inc),
    .count (cyc)
  );

  always_comb begin
    bus.phase       = state;
    bus.locked      = (state != S_SYNC) &&
                      (state != S_FAULT);
    bus.error       = (state == S_FAULT);
    bus.err_code    = code;
    bus.cycle_count = cyc;
  end

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed checks of the traffic light monitor
// with hand-computed expected values.
module tb_traffic_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  traffic_monitor_if bus ();

  traffic_monitor #(.MAX_DWELL(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(
    input logic [2:0] p,
    input logic       clr
  );
    {bus.green, bus.amber, bus.red} = p;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(
    input string      tag,
    input logic [2:0] ph,
    input logic       lk,
    input logic       er,
    input logic [1:0] ec,
    input logic [7:0] cc
  );
    chk({tag, ".phase"}, 8'(bus.phase), 8'(ph));
    chk({tag, ".locked"}, 8'(bus.locked), 8'(lk));
    chk({tag, ".error"}, 8'(bus.error), 8'(er));
    chk({tag, ".code"}, 8'(bus.err_code), 8'(ec));
    chk({tag, ".cyc"}, bus.cycle_count, cc);
  endtask

  initial begin
    bus.red = 1'b0;
    bus.amber = 1'b0;
    bus.green = 1'b0;
    bus.err_clr = 1'b0;

    rst_n = 1'b0;
    step(3'b111, 1'b1);
    step(3'b111, 1'b1);
    chk_all("rst", 3'b000, 0, 0, 2'b00, 8'd0);
    rst_n = 1'b1;

    step(3'b001, 1'b0);
    chk_all("seq_r", 3'b001, 1, 0, 2'b00, 8'd0);
    step(3'b011, 1'b0);
    chk("seq_ra", 8'(bus.phase), 8'h03);
    step(3'b100, 1'b0);
    chk("seq_g", 8'(bus.phase), 8'h04);
    step(3'b010, 1'b0);
    chk_all("seq_a", 3'b010, 1, 0, 2'b00, 8'd0);
    step(3'b001, 1'b0);
    chk_all("seq_r2", 3'b001, 1, 0, 2'b00, 8'd1);

    step(3'b100, 1'b0);
    chk_all("trans", 3'b111, 0, 1, 2'b10, 8'd1);
    step(3'b000, 1'b0);
    chk_all("hold", 3'b111, 0, 1, 2'b10, 8'd1);
    step(3'b001, 1'b1);
    chk_all("clr", 3'b000, 0, 0, 2'b00, 8'd1);

    step(3'b100, 1'b0);
    chk_all("sync_g", 3'b000, 0, 0, 2'b00, 8'd1);
    step(3'b010, 1'b0);
    chk_all("sync_a", 3'b000, 0, 0, 2'b00, 8'd1);
    step(3'b001, 1'b0);
    chk_all("sync_r", 3'b001, 1, 0, 2'b00, 8'd1);
    step(3'b001, 1'b1);
    chk_all("clr_ign", 3'b001, 1, 0, 2'b00, 8'd1);

    step(3'b011, 1'b0);
    step(3'b100, 1'b0);
    for (int i = 0; i < 15; i++)
      step(3'b100, 1'b0);
    chk_all("dwell16", 3'b100, 1, 0, 2'b00, 8'd1);
    step(3'b100, 1'b0);
    chk_all("dwell17", 3'b111, 0, 1, 2'b11, 8'd1);
    step(3'b000, 1'b1);
    chk("dw_clr", 8'(bus.phase), 8'h00);

    step(3'b001, 1'b0);
    step(3'b011, 1'b0);
    chk("ra", 8'(bus.phase), 8'h03);
    step(3'b111, 1'b0);
    chk_all("illegal", 3'b111, 0, 1, 2'b01, 8'd1);
    step(3'b001, 1'b1);
    step(3'b000, 1'b0);
    chk_all("sync_ill", 3'b111, 0, 1, 2'b01, 8'd1);
    step(3'b001, 1'b1);
    chk("clr2", 8'(bus.err_code), 8'h00);

    step(3'b001, 1'b0);
    for (int k = 1; k <= 260; k++) begin
      step(3'b011, 1'b0);
      step(3'b100, 1'b0);
      step(3'b010, 1'b0);
      step(3'b001, 1'b0);
      if (k == 100)
        chk("cyc101", bus.cycle_count, 8'd101);
      if (k == 253)
        chk("cyc254", bus.cycle_count, 8'd254);
      if (k == 254)
        chk("cyc255", bus.cycle_count, 8'd255);
    end
    chk_all("sat", 3'b001, 1, 0, 2'b00, 8'd255);

    step(3'b011, 1'b0);
    step(3'b100, 1'b0);
    rst_n = 1'b0;
    step(3'b010, 1'b0);
    chk_all("rst_mid", 3'b000, 0, 0, 2'b00, 8'd0);
    rst_n = 1'b1;
    step(3'b001, 1'b0);
    chk_all("post_rst", 3'b001, 1, 0, 2'b00, 8'd0);

    step(3'b101, 1'b0);
    chk("flt", 8'(bus.err_code), 8'h01);
    rst_n = 1'b0;
    step(3'b101, 1'b0);
    chk_all("rst_flt", 3'b000, 0, 0, 2'b00, 8'd0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
